// File: rtl/sbox_serial.sv
// Nibble-serial 4-bit S-box substitution layer.
// One word is accepted over valid/ready, substituted one nibble per clock,
// and presented over valid/ready. INV selects the inverse table.
module sbox_serial #(
  parameter int unsigned NIBBLES = 4,
  parameter bit          INV     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    data_q;
  logic [W-1:0]    sub_word;
  logic            last_nib;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    if (!INV) begin
      case (x)
        4'h0: y = 4'h1;  4'h1: y = 4'h3;  4'h2: y = 4'h0;  4'h3: y = 4'h2;
        4'h4: y = 4'h7;  4'h5: y = 4'hE;  4'h6: y = 4'h4;  4'h7: y = 4'hD;
        4'h8: y = 4'h9;  4'h9: y = 4'hB;  4'hA: y = 4'hC;  4'hB: y = 4'h8;
        4'hC: y = 4'h5;  4'hD: y = 4'h6;  4'hE: y = 4'hF;  default: y = 4'hA;
      endcase
    end else begin
      case (x)
        4'h0: y = 4'h2;  4'h1: y = 4'h0;  4'h2: y = 4'h3;  4'h3: y = 4'h1;
        4'h4: y = 4'h6;  4'h5: y = 4'hC;  4'h6: y = 4'hD;  4'h7: y = 4'h4;
        4'h8: y = 4'hB;  4'h9: y = 4'h8;  4'hA: y = 4'hF;  4'hB: y = 4'h9;
        4'hC: y = 4'hA;  4'hD: y = 4'h7;  4'hE: y = 4'h5;  default: y = 4'hE;
      endcase
    end
    return y;
  endfunction

  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  // Word with only the nibble selected by cnt_q replaced by its substitution.
  always_comb begin
    sub_word = data_q;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (cnt_q == CW'(k)) begin
        sub_word[4*k +: 4] = sbox(data_q[4*k +: 4]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data register and nibble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            cnt_q  <= '0;
          end
        end
        BUSY: begin
          data_q <= sub_word;
          cnt_q  <= last_nib ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset interval.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = data_q;

endmodule
